// File: rtl/reg_file_sb_if.sv
// Register file bus: write, issue, clear request and two read ports with their pending flags.
interface reg_file_sb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          clr_req;
  logic          busy;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          iss;
  logic [AW-1:0] iss_addr;
  logic          pend_a;
  logic          pend_b;

  modport master (
    output clr_req, we, waddr, wdata, raddr_a, raddr_b, iss, iss_addr,
    input  busy, rdata_a, rdata_b, pend_a, pend_b
  );

  modport slave (
    input  clr_req, we, waddr, wdata, raddr_a, raddr_b, iss, iss_addr,
    output busy, rdata_a, rdata_b, pend_a, pend_b
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with write bypass, hardwired zero entry, pending scoreboard and
// a falling-edge clear sweep that defines every entry after reset or flush.
module reg_file_sb_rport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] word,
  input  logic          pend_bit,
  input  logic          busy,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          pend
);
  logic hit, zero;

  assign hit  = (BYPASS != 0) && we && (waddr == raddr) && !busy;
  assign zero = (ZERO_REG != 0) && (raddr == '0);

  always_comb begin
    rdata = word;
    if (zero || busy) rdata = '0;
    else if (hit)     rdata = wdata;
  end

  // A forwarded write retires the producer, so the entry no longer looks pending.
  assign pend = pend_bit & ~hit & ~zero & ~busy;
endmodule

module reg_file_sb #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int NPORT = 2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                     state_q, state_d;
  logic [AW-1:0]              ptr_q, ptr_d;
  logic [DEPTH-1:0]           pend_q, pend_d;
  logic [DEPTH-1:0][DW-1:0]   mem;
  logic                       busy, wr_ok, iss_ok;

  logic [NPORT-1:0][AW-1:0]   raddr;
  logic [NPORT-1:0][DW-1:0]   rdata;
  logic [NPORT-1:0]           pend;

  assign busy     = (state_q == CLEAR);
  assign bus.busy = busy;
  assign wr_ok    = !busy && bus.we  && !((ZERO_REG != 0) && (bus.waddr == '0));
  assign iss_ok   = !busy && bus.iss && !((ZERO_REG != 0) && (bus.iss_addr == '0));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (bus.clr_req) ptr_d = '0;
        else if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else ptr_d = ptr_q + AW'(1);
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Issue is applied after the write so a same-edge new producer keeps the entry pending.
  always_comb begin
    pend_d = pend_q;
    if (bus.clr_req) pend_d = '0;
    else begin
      if (wr_ok)  pend_d[bus.waddr]    = 1'b0;
      if (iss_ok) pend_d[bus.iss_addr] = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  // Array is left unreset; the sweep defines it before any read can observe it.
  always_ff @(negedge clk) begin
    if (busy)       mem[ptr_q]     <= '0;
    else if (wr_ok) mem[bus.waddr] <= bus.wdata;
  end

  assign raddr = {bus.raddr_b, bus.raddr_a};

  for (genvar g = 0; g < NPORT; g++) begin : g_rport
    reg_file_sb_rport #(
      .DW(DW), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rport (
      .raddr    (raddr[g]),
      .word     (mem[raddr[g]]),
      .pend_bit (pend_q[raddr[g]]),
      .busy     (busy),
      .we       (bus.we),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .rdata    (rdata[g]),
      .pend     (pend[g])
    );
  end

  assign bus.rdata_a = rdata[0];
  assign bus.rdata_b = rdata[1];
  assign bus.pend_a  = pend[0];
  assign bus.pend_b  = pend[1];
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised general-purpose register file with two combinational read ports, one write port, an optional write-to-read bypass, a hardwired zero register, a per-entry pending scoreboard and a sequential clear engine.
- Sits in the CPU datapath between decode (reads, issue) and writeback (write).
- The clear engine zeroes the whole array after reset or on a flush request, so contents are always defined.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; DEPTH = 2**AW entries.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = reads see array contents only.
- ZERO_REG, 1, 1 = entry 0 always reads 0, is never written and is never pending.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  reset, asynchronous, active-low.
- clr_req  in  1  flush request; (re)starts the clear sweep.
- busy  out  1  clear sweep in progress.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  DW  write data.
- raddr_a  in  AW  read address A.
- raddr_b  in  AW  read address B.
- rdata_a  out  DW  read data A.
- rdata_b  out  DW  read data B.
- iss  in  1  issue: mark iss_addr pending.
- iss_addr  in  AW  destination being issued.
- pend_a  out  1  entry raddr_a awaits writeback.
- pend_b  out  1  entry raddr_b awaits writeback.

Behaviour:
- Reset asserted (low): busy=1, sweep pointer=0, all pending bits=0, immediately and independent of clk. The array itself is not reset.
- Reset outputs: rdata_a=rdata_b=0 (because busy=1), pend_a=pend_b=0.
- Clear sweep (states IDLE, CLEAR):
  - In CLEAR, each falling edge writes data[ptr]<=0 and increments ptr.
  - The edge that clears entry DEPTH-1 sets busy<=0, moves to IDLE and wraps ptr to 0.
  - busy is high for exactly DEPTH falling edges after reset release.
- clr_req:
  - Sampled at the falling edge in IDLE: next state CLEAR, ptr<=0, all pending<=0.
  - Sampled in CLEAR: ptr restarts at 0 and the sweep takes another full DEPTH edges.
- While busy: we and iss are ignored, and rdata_a/b and pend_a/b are forced to 0.
- Write, in IDLE only: if we=1, data[waddr]<=wdata and pending[waddr]<=0. If ZERO_REG=1 and waddr=0, there is no effect.
- Issue, in IDLE only: if iss=1, pending[iss_addr]<=1. If ZERO_REG=1 and iss_addr=0, it is ignored.
- Issue and write to the same address on the same edge: pending ends at 1, because issue wins (a new producer). Data is still written.
- Read priority for each port, combinational, zero cycles:
  1. ZERO_REG and raddr=0 -> 0.
  2. busy -> 0.
  3. BYPASS and we and waddr==raddr (and the address is non-zero when ZERO_REG=1) -> wdata.
  4. Otherwise data[raddr].
- pend_x = pending[raddr_x] & ~(BYPASS & we & waddr==raddr_x & ~busy). A forwarded write shows as not pending; pend_x=0 for entry 0 when ZERO_REG=1.
- Both ports may address the same entry; both return identical values.
- Reset asserted mid-sweep or mid-operation: state returns to CLEAR, ptr=0, pending=0 at once, and the sweep restarts after release.

Test Plan:
- Reset low 3 cycles, then release (DW=32, AW=5) -> busy=1 for exactly 32 falling edges. we=1 waddr=3 wdata=0xDEADBEEF during the sweep is ignored, and raddr_a=3 reads 0 after busy falls.
- IDLE, we=1 waddr=7 wdata=0x12345678, raddr_a=7, BYPASS=1 -> rdata_a=0x12345678 in the same cycle. With BYPASS=0, the value appears only after the falling edge.
- we=1 waddr=0 wdata=0xFFFFFFFF, then raddr_a=raddr_b=0 -> rdata_a=rdata_b=0. iss with iss_addr=0 leaves pend_a=0.
- iss=1 iss_addr=5 -> pend_a=1 for raddr_a=5. Then we=1 waddr=5 -> pend_a=0 combinationally, and stays 0 after the edge. iss and we both to 9 on one edge -> pend(9)=1 and data[9] is updated.
- After writing 0xA5 to entries 1..31, assert clr_req for one edge -> busy=1 and pending cleared. A second clr_req at sweep edge 10 extends busy to 32 edges from the second request. All entries then read 0.
- Assert reset at sweep edge 12 -> busy stays 1 and ptr=0. The full 32-edge sweep follows release, and pend_a/b=0 throughout.
